// File: rtl/flit_serializer_4_if.sv
`default_nettype none
// ============================================================================
//  Module      : flit_serializer_4_if
//  Description : Injection-side bundle for flit_serializer_4. It carries the
//                packed word handshake from the packetizer, the flit output to
//                the router, and the per-VC credit-return pulses.
//  Revision    : 1.0  initial release
// ============================================================================
interface flit_serializer_4_if #(
    parameter int WIDTH_IN         = 36,
    parameter int VC_ADDRESS_WIDTH = 1
);
    localparam int c_FLIT_WIDTH = WIDTH_IN / 4;
    localparam int c_NUM_VC     = 2 ** VC_ADDRESS_WIDTH;

    logic [WIDTH_IN-1:0]     i_data_in;
    logic                    i_valid_in;
    logic                    i_ready_out;
    logic [c_FLIT_WIDTH-1:0] o_flit_out;
    logic [c_NUM_VC-1:0]     i_credit_in;
    logic                    o_credit_err;

    // Upstream packetizer / router side
    modport master (
        output i_data_in,
        output i_valid_in,
        output i_credit_in,
        input  i_ready_out,
        input  o_flit_out,
        input  o_credit_err
    );

    // Serializer side
    modport slave (
        input  i_data_in,
        input  i_valid_in,
        input  i_credit_in,
        output i_ready_out,
        output o_flit_out,
        output o_credit_err
    );
endinterface
`default_nettype wire

// File: rtl/flit_serializer_4.sv
`default_nettype none
// ============================================================================
//  Module      : flit_serializer_4
//  Description : Takes a packed word of up to four flits and issues the valid
//                ones one per cycle, head first, onto the router injection
//                port. Each issue consumes a credit of the flit's VC; credits
//                come back as one-cycle pulses from the router.
//  Revision    : 1.0  initial release
// ============================================================================
module flit_serializer_4 #(
    parameter int WIDTH_IN         = 36,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int CREDIT_COUNT     = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    flit_serializer_4_if.slave bus
);
    localparam int c_FLIT_WIDTH = WIDTH_IN / 4;
    localparam int c_NUM_VC     = 2 ** VC_ADDRESS_WIDTH;
    localparam int c_CW         = $clog2(CREDIT_COUNT + 1);

    // Flit header bit positions: {valid, head, tail, vc, payload}
    localparam int c_V_BIT  = c_FLIT_WIDTH - 1;
    localparam int c_H_BIT  = c_FLIT_WIDTH - 2;
    localparam int c_T_BIT  = c_FLIT_WIDTH - 3;
    localparam int c_VC_LSB = c_FLIT_WIDTH - 3 - VC_ADDRESS_WIDTH;

    localparam logic [c_FLIT_WIDTH-1:0] c_VALID_MASK = {1'b1, {(c_FLIT_WIDTH-1){1'b0}}};
    localparam logic [c_CW-1:0]         c_CREDIT_MAX = c_CW'(CREDIT_COUNT);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_SEND = 1'b1;

    logic [0:0]                      r_state;
    logic [0:0]                      w_state_nxt;
    logic [1:0]                      r_idx;
    logic [1:0]                      w_idx_nxt;
    // Flit 0 lives in the most significant quarter, i.e. element 3
    logic [3:0][c_FLIT_WIDTH-1:0]    r_word;
    logic [c_FLIT_WIDTH-1:0]         r_flit_out;
    logic                            r_credit_err;
    logic [c_NUM_VC-1:0][c_CW-1:0]   r_credit;
    logic [c_NUM_VC-1:0][c_CW-1:0]   w_credit_nxt;
    logic [c_NUM_VC-1:0]             w_ovf;

    logic [c_FLIT_WIDTH-1:0]         w_flit;
    logic [VC_ADDRESS_WIDTH-1:0]     w_vc;
    logic                            w_has_credit;
    logic                            w_drop;
    logic                            w_issue;
    logic                            w_last;
    logic                            w_ready;
    logic                            w_accept;

    assign w_flit       = r_word[2'd3 - r_idx];
    assign w_vc         = w_flit[c_VC_LSB +: VC_ADDRESS_WIDTH];
    assign w_has_credit = (r_credit[w_vc] != '0);

    // A word whose first flit is not a valid head is not a packet at all
    assign w_drop   = (r_state == c_S_SEND) && (r_idx == 2'd0) &&
                      (!w_flit[c_V_BIT] || !w_flit[c_H_BIT]);
    assign w_issue  = (r_state == c_S_SEND) && !w_drop && w_has_credit;
    assign w_last   = w_issue && (w_flit[c_T_BIT] || (r_idx == 2'd3));
    // Ready opens on the tail-issue cycle so back-to-back packets have no bubble
    assign w_ready  = !rst && ((r_state == c_S_IDLE) || w_last);
    assign w_accept = bus.i_valid_in && w_ready;

    assign bus.i_ready_out  = w_ready;
    assign bus.o_flit_out   = r_flit_out;
    assign bus.o_credit_err = r_credit_err;

    // Per-VC credit arithmetic: return +1, issue -1, both cancel, saturate at max
    for (genvar g = 0; g < c_NUM_VC; g++) begin : g_credit
        logic w_inc;
        logic w_dec;
        logic w_full;

        assign w_inc    = bus.i_credit_in[g];
        assign w_dec    = w_issue && (w_vc == VC_ADDRESS_WIDTH'(g));
        assign w_full   = (r_credit[g] == c_CREDIT_MAX);
        assign w_ovf[g] = w_inc && !w_dec && w_full;
        assign w_credit_nxt[g] = (w_inc && !w_dec && !w_full) ? r_credit[g] + c_CW'(1) :
                                 (w_dec && !w_inc)            ? r_credit[g] - c_CW'(1) :
                                                                r_credit[g];
    end

    // Next-state and flit index selection
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_S_SEND;
                    w_idx_nxt   = 2'd0;
                end
            end
            c_S_SEND: begin
                if (w_drop) begin
                    w_state_nxt = c_S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = w_accept ? c_S_SEND : c_S_IDLE;
                    w_idx_nxt   = 2'd0;
                end else if (w_issue) begin
                    w_idx_nxt   = r_idx + 2'd1;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_idx_nxt   = 2'd0;
            end
        endcase
    end

    // State, held word, registered flit output and credit counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_S_IDLE;
            r_idx        <= 2'd0;
            r_word       <= '0;
            r_flit_out   <= '0;
            r_credit_err <= 1'b0;
            for (int v = 0; v < c_NUM_VC; v++) begin
                r_credit[v] <= c_CREDIT_MAX;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            if (w_accept) begin
                r_word <= bus.i_data_in;
            end
            r_flit_out   <= w_issue ? (w_flit | c_VALID_MASK) : '0;
            r_credit_err <= r_credit_err | (|w_ovf);
            r_credit     <= w_credit_nxt;
        end
    end
endmodule
`default_nettype wire
